// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: elastic chain of DEPTH valid/data register stages.
// Empty stages are filled as items move forward, so a stall at the output
// only blocks the stages that are actually occupied. A per-stage flush mask
// clears selected stages at the next edge, and it takes priority over any load.
module pipe_stage_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WIDTH-1:0]   i_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [WIDTH-1:0]   o_data,
  input  logic [DEPTH-1:0]   i_flush_mask,
  output logic [CW-1:0]      o_count
);

  logic [DEPTH-1:0]             v_q, v_d;
  logic [DEPTH-1:0][WIDTH-1:0]  d_q, d_d;
  logic [DEPTH-1:0]             acc;
  logic [DEPTH:0]               src_v;
  logic [DEPTH:0][WIDTH-1:0]    src_d;
  logic [CW-1:0]                count;

  // Entry k of src_* is what stage k loads: the upstream input for stage 0,
  // and the previous stage for every other stage.
  assign src_v = {v_q, i_valid};
  assign src_d = {d_q, i_data};

  // Accept chain from the output back to the input. A stage may load when it
  // is empty or when every stage after it can also make room. Flush is left
  // out on purpose, so a flush never changes o_ready in the same cycle.
  always_comb begin
    logic room;
    acc  = '0;
    room = i_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      room   = room | ~v_q[k];
      acc[k] = room;
    end
  end

  // Next state of each stage: load when the stage can accept, otherwise hold.
  // A flush of stage k then overrides whatever stage k would have loaded.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (acc[k]) begin
        v_d[k] = src_v[k];
        d_d[k] = src_d[k];
      end
      if (i_flush_mask[k]) begin
        v_d[k] = 1'b0;
        d_d[k] = '0;
      end
    end
  end

  // Occupancy: number of valid stages, taken from the current flops.
  always_comb begin
    count = '0;
    for (int k = 0; k < DEPTH; k++) begin
      count = count + CW'(v_q[k]);
    end
  end

  // Stage registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      v_q <= '0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign o_ready = acc[0];
  assign o_valid = v_q[DEPTH-1];
  assign o_data  = d_q[DEPTH-1];
  assign o_count = count;

endmodule
